booth_sequencer: RTL and testbench

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

---
 rtl/booth_sequencer.sv | 127 ++++++++++++
 tb/tb_booth_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_sequencer.sv
// -----------------------------------------------------------------------------
// booth_sequencer
//
// Control and operand side of a radix-4 Booth multiplier, 64 x 64 -> 128 bits,
// signed. The block produces one Booth partial product per step. An external
// result controller folds it into the accumulator and hands the next
// accumulator value back on resultIn. The expected fold is
//   resultIn = (product >>> 2) + shiftedNumber
// Each step adds digit*M at weight 2^62, and the 31 later right shifts bring
// it down to its true weight. After 32 accepted steps the accumulator holds
// M*Q exactly.
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous reset, active low
//   start          begin a multiplication (accepted only while idle)
//   multiplicand   signed M, captured with start
//   multiplier     signed Q, captured with start
//   resultIn       next accumulator value from the result controller
//   resultEnabler  accept strobe from the result controller; one step per high cycle
//   op             state code: 00 idle, 01 calculating, 10 done
//   shiftedNumber  current partial product, sign-extended digit*M placed at bit 62
//   product        accumulator register
//   done           high for the single cycle in which op = 10
// -----------------------------------------------------------------------------
module booth_sequencer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  input  logic [127:0] resultIn,
  input  logic         resultEnabler,
  output logic [1:0]   op,
  output logic [127:0] shiftedNumber,
  output logic [127:0] product,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    CALCULATING = 2'b01,
    DONE        = 2'b10
  } stateT;

  stateT               state;
  logic signed [63:0]  mReg;
  // Multiplier with an appended 0 below the LSB. Bits [2:0] form the
  // current Booth window.
  logic signed [64:0]  qReg;
  logic [4:0]          stepCount;
  logic signed [127:0] productReg;
  logic                doneReg;

  // Radix-4 Booth recoding of a 3-bit window into digit*M. The result is 66
  // bits wide so that -2 * (-2^63) = +2^64 is still representable.
  function automatic logic signed [65:0] boothPartial(
    input logic signed [63:0] m,
    input logic        [2:0]  code
  );
    logic signed [65:0] mExt;
    mExt = {{2{m[63]}}, m};
    unique case (code)
      3'b001, 3'b010: boothPartial = mExt;
      3'b011:         boothPartial = mExt <<< 1;
      3'b100:         boothPartial = -(mExt <<< 1);
      3'b101, 3'b110: boothPartial = -mExt;
      default:        boothPartial = '0;
    endcase
  endfunction

  // The partial product depends only on registered state. Outside the
  // calculation it is forced to 0, so the controller folds in nothing.
  always_comb begin
    shiftedNumber = '0;
    if (state == CALCULATING) begin
      shiftedNumber = {boothPartial(mReg, qReg[2:0]), 62'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mReg       <= '0;
      qReg       <= '0;
      stepCount  <= '0;
      productReg <= '0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mReg       <= multiplicand;
            qReg       <= {multiplier, 1'b0};
            productReg <= '0;
            stepCount  <= '0;
            state      <= CALCULATING;
          end
        end
        CALCULATING: begin
          // A low accept strobe stalls every register.
          if (resultEnabler) begin
            productReg <= resultIn;
            qReg       <= qReg >>> 2;
            stepCount  <= stepCount + 5'd1;
            if (stepCount == 5'd31) begin
              state   <= DONE;
              doneReg <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign op      = state;
  assign product = productReg;
  assign done    = doneReg;

endmodule

// File: tb/tb_booth_sequencer.sv
// -----------------------------------------------------------------------------
// tb_booth_sequencer
//
// Randomised scoreboard bench for booth_sequencer. The stimulus process plays
// the result controller's accept pattern. It also pushes the exact signed
// product, together with the cycle in which done must appear. A monitor pops
// the queue on every done pulse and checks the per-cycle output rules. The
// result controller is modelled as resultIn = (product >>> 2) + shiftedNumber.
// -----------------------------------------------------------------------------
module tb_booth_sequencer;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [63:0]         multiplicand;
  logic [63:0]         multiplier;
  logic signed [127:0] resultIn;
  logic                resultEnabler;
  logic [1:0]          op;
  logic signed [127:0] shiftedNumber;
  logic signed [127:0] product;
  logic                done;

  booth_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .resultIn      (resultIn),
    .resultEnabler (resultEnabler),
    .op            (op),
    .shiftedNumber (shiftedNumber),
    .product       (product),
    .done          (done)
  );

  // Result controller model.
  assign resultIn = (product >>> 2) + shiftedNumber;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [127:0] prod;
    int                  doneCyc;
  } sbT;

  sbT sb[$];
  sbT monE;
  int vectors     = 0;
  int miscompares = 0;
  bit monOn       = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pickOperand();
    logic [63:0] v;
    case ($urandom_range(5, 0))
      0:       v = 64'h8000_0000_0000_0000;
      1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      2:       v = '1;
      3:       v = 64'($urandom_range(15, 0));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // mode 0: accept strobe always high.
  // mode 1: random stalls.
  // mode 2: exactly 10 stall cycles at random positions mid-run.
  // disturb: pulse start with new operands mid-run and again in the DONE cycle.
  // abortAt >= 0: drop reset after that many accepted steps.
  task automatic runOp(input logic [63:0] m, input logic [63:0] q, input int mode,
                       input bit disturb, input int abortAt);
    bit                  pat[100];
    int                  ones;
    int                  k;
    int                  s;
    int                  dg;
    logic signed [127:0] mw, qw, dw, expP, expPart;
    sbT                  e;

    for (int i = 0; i < 100; i++) pat[i] = 1'b1;
    if (mode == 1) begin
      for (int i = 0; i < 68; i++) pat[i] = ($urandom_range(3, 0) != 0);
    end else if (mode == 2) begin
      for (int z = 0; z < 10; z++) begin
        int idx;
        do idx = $urandom_range(38, 3); while (pat[idx] == 1'b0);
        pat[idx] = 1'b0;
      end
    end
    ones = 0;
    k    = 0;
    for (int i = 0; i < 100; i++) begin
      if (pat[i]) ones++;
      if (ones == 32) begin
        k = i;
        break;
      end
    end

    mw   = {{64{m[63]}}, m};
    qw   = {{64{q[63]}}, q};
    expP = mw * qw;
    dg   = -2 * int'(q[1]) + int'(q[0]);
    dw   = dg;
    expPart = (mw * dw) <<< 62;

    @(posedge clk); #1;
    start         = 1'b1;
    multiplicand  = m;
    multiplier    = q;
    resultEnabler = 1'($urandom_range(1, 0));
    s = cyc + 1;
    if (abortAt < 0) begin
      e.prod    = expP;
      e.doneCyc = s + 1 + k;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    chk("startOp", op, 2'b01);
    chk("firstPartial", shiftedNumber, expPart);

    ones = 0;
    for (int i = 0; i <= k; i++) begin
      if (abortAt >= 0 && i == abortAt) begin
        reset_n       = 1'b0;
        start         = 1'b1;
        resultEnabler = 1'b1;
        @(posedge clk); #1;
        chk("abortOp", op, 2'b00);
        chk("abortProduct", product, 128'd0);
        chk("abortDone", done, 1'b0);
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abortStaysIdle", op, 2'b00);
        return;
      end
      resultEnabler = pat[i];
      if (disturb && i == 10) begin
        start        = 1'b1;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (pat[i]) ones++;
      if (ones < 32) chk("calcOp", op, 2'b01);
    end

    chk("doneOp", op, 2'b10);
    // This edge is the DONE -> IDLE edge. A start here must be dropped.
    start         = disturb;
    resultEnabler = 1'($urandom_range(1, 0));
    @(posedge clk); #1;
    start = 1'b0;
    if (disturb) repeat (40) @(posedge clk);
    else repeat (2) @(posedge clk);
    #1;
    chk("idleOp", op, 2'b00);
    chk("holdProduct", product, expP);
  endtask

  always @(negedge clk) begin
    if (monOn && reset_n) begin
      chk("doneVsOp", done, (op == 2'b10));
      chk("shiftLowBits", shiftedNumber[61:0], 62'd0);
      if (op != 2'b01) chk("shiftOutsideCalc", shiftedNumber, 128'd0);
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpectedDone: got done=1 expected no pending operation (cycle %0d)", cyc);
        end else begin
          monE = sb.pop_front();
          chk("product", product, monE.prod);
          chk("doneCycle", 128'(cyc), 128'(monE.doneCyc));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "time limit reached");
  end

  initial begin
    reset_n       = 1'b0;
    start         = 1'b1;
    resultEnabler = 1'b1;
    multiplicand  = {$urandom, $urandom};
    multiplier    = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("resetOp", op, 2'b00);
    chk("resetProduct", product, 128'd0);
    chk("resetDone", done, 1'b0);
    chk("resetShift", shiftedNumber, 128'd0);
    reset_n = 1'b1;
    start   = 1'b0;
    monOn   = 1'b1;

    runOp(64'd3, 64'd5, 0, 1'b0, -1);
    runOp('1, '1, 0, 1'b0, -1);
    runOp(64'h7FFF_FFFF_FFFF_FFFF, '1, 0, 1'b0, -1);
    runOp(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0, -1);
    runOp(64'd7, 64'd9, 2, 1'b0, -1);
    runOp({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1, -1);
    runOp({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 15);
    runOp(-64'sd5, 64'd11, 0, 1'b0, -1);
    for (int n = 0; n < 25; n++) begin
      runOp(pickOperand(), pickOperand(), 1, 1'($urandom_range(1, 0)), -1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboardDrained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
